// File: rtl/get_req_pkg.sv
// Shared types and constants for the HTTP request-line sequencer.
// The state encoding is numeric-significant: loadk = 3k+1, waitloadk = 3k+2, waitsendk = 3k+3.
package get_req_pkg;

    localparam int unsigned MSG_LEN = 19;

    typedef enum logic [5:0] {
        init = 6'd0,
        load0,  waitload0,  waitsend0,
        load1,  waitload1,  waitsend1,
        load2,  waitload2,  waitsend2,
        load3,  waitload3,  waitsend3,
        load4,  waitload4,  waitsend4,
        load5,  waitload5,  waitsend5,
        load6,  waitload6,  waitsend6,
        load7,  waitload7,  waitsend7,
        load8,  waitload8,  waitsend8,
        load9,  waitload9,  waitsend9,
        load10, waitload10, waitsend10,
        load11, waitload11, waitsend11,
        load12, waitload12, waitsend12,
        load13, waitload13, waitsend13,
        load14, waitload14, waitsend14,
        load15, waitload15, waitsend15,
        load16, waitload16, waitsend16,
        load17, waitload17, waitsend17,
        load18, waitload18, waitsend18,
        finish
    } state_e;

    // "GET /req HTTP/1.0\r\n"
    localparam logic [7:0] MSG_ROM [MSG_LEN] = '{
        8'h47, 8'h45, 8'h54, 8'h20, 8'h2F, 8'h72, 8'h65, 8'h71, 8'h20, 8'h48,
        8'h54, 8'h54, 8'h50, 8'h2F, 8'h31, 8'h2E, 8'h30, 8'h0D, 8'h0A
    };

    // 0 = load, 1 = waitload, 2 = waitsend, 3 = init/finish
    function automatic logic [1:0] phase_of(input state_e s);
        logic [5:0] v;
        v = s;
        if (s == init || s == finish) return 2'd3;
        v = v - 6'd1;
        return 2'(v % 6'd3);
    endfunction

    function automatic logic [4:0] byte_idx(input state_e s);
        logic [5:0] v;
        v = s;
        v = v - 6'd1;
        return 5'(v / 6'd3);
    endfunction

endpackage

// File: rtl/get_req_fsm.sv
// Streams the fixed request line into the UART transmitter, one byte per
// load strobe, paced by txempty; pulses done once the last byte is taken.
module get_req_fsm
    import get_req_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       txempty,
    output logic       done,
    output logic [7:0] txdata,
    output logic       ldtxdata
);

    state_e     state, state_d;
    logic       ldtxdata_q, ldtxdata_d;
    logic       done_q, done_d;
    logic [7:0] txdata_q, txdata_d;

    // Every state other than init/finish advances by one, except waitsend
    // which waits for txempty; this leans on the interleaved encoding.
    always_comb begin
        state_d = state;
        if (state == init) begin
            if (start) state_d = load0;
        end else if (state == finish) begin
            state_d = init;
        end else if (phase_of(state) != 2'd2 || txempty) begin
            state_d = state_e'(state + 6'd1);
        end

        ldtxdata_d = (phase_of(state_d) == 2'd0);
        txdata_d   = ldtxdata_d ? MSG_ROM[byte_idx(state_d)] : txdata_q;
        done_d     = (state == finish);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= init;
            ldtxdata_q <= 1'b0;
            done_q     <= 1'b0;
            txdata_q   <= '0;
        end else begin
            state      <= state_d;
            ldtxdata_q <= ldtxdata_d;
            done_q     <= done_d;
            txdata_q   <= txdata_d;
        end
    end

    assign ldtxdata = ldtxdata_q;
    assign done     = done_q;
    assign txdata   = txdata_q;

endmodule

// File: tb/tb_get_req_fsm.sv
// Randomised and directed bench for get_req_fsm against a numeric reference model.
module tb_get_req_fsm;

    logic       clk = 1'b0;
    logic       rst_n, start, txempty;
    logic       done, ldtxdata;
    logic [7:0] txdata;

    get_req_fsm dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .txempty  (txempty),
        .done     (done),
        .txdata   (txdata),
        .ldtxdata (ldtxdata)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: states numbered 0 (init), 1..57 (3 per byte), 58 (finish)
    string      MSG = "GET /req HTTP/1.0\r\n";
    int         m_state;
    logic       m_done;
    logic [7:0] m_txd;

    function automatic bit m_is_load(input int s);
        return (s >= 1) && (s <= 57) && ((s - 1) % 3 == 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0;
            m_done  = 1'b0;
            m_txd   = 8'h00;
        end else begin
            int nxt;
            if (m_state == 0)                                   nxt = start ? 1 : 0;
            else if (m_state == 58)                             nxt = 0;
            else if (((m_state - 1) % 3 == 2) && !txempty)      nxt = m_state;
            else                                                nxt = m_state + 1;
            m_done = (m_state == 58);
            if (m_is_load(nxt)) m_txd = MSG[(nxt - 1) / 3];
            m_state = nxt;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("model_state",    int'(dut.state), m_state);
            chk("model_ldtxdata", int'(ldtxdata),  int'(m_is_load(m_state)));
            chk("model_txdata",   int'(txdata),    int'(m_txd));
            chk("model_done",     int'(done),      int'(m_done));
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] got[$];
        bit found;
        int gap, ldc;

        rst_n = 1'b0; start = 1'b0; txempty = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_state",  int'(dut.state), 0);
        chk("reset_ld",     int'(ldtxdata),  0);
        chk("reset_done",   int'(done),      0);
        chk("reset_txdata", int'(txdata),    0);

        // Start handshake with txempty low
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("load0_state",  int'(dut.state), 1);
        chk("load0_ld",     int'(ldtxdata),  1);
        chk("load0_txdata", int'(txdata),    8'h47);
        @(negedge clk);
        chk("waitload0_state", int'(dut.state), 2);
        @(negedge clk);
        chk("waitsend0_state", int'(dut.state), 3);
        @(negedge clk);
        chk("waitsend0_hold",  int'(dut.state), 3);

        // Manual pacing through every byte
        for (int k = 0; k < 19; k++) begin
            txempty = 1'b1;
            @(negedge clk);
            txempty = 1'b0;
            if (k < 18) begin
                chk("pace_state", int'(dut.state), 3 * k + 4);
                chk("pace_ld",    int'(ldtxdata),  1);
                if (k == 3)  chk("load4_txdata",  int'(txdata), 8'h2F);
                if (k == 16) chk("load17_txdata", int'(txdata), 8'h0D);
                repeat (2 + $urandom_range(0, 2)) @(negedge clk);
            end
        end
        chk("finish_state", int'(dut.state), 58);
        @(negedge clk);
        chk("done_pulse", int'(done),      1);
        chk("done_init",  int'(dut.state), 0);
        @(negedge clk);
        chk("done_clear", int'(done),      0);

        // Full run with txempty stuck high
        txempty = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (ldtxdata) got.push_back(txdata);
            if (done) begin
                found = 1'b1;
                chk("full_state_at_done", int'(dut.state), 0);
            end else begin
                @(negedge clk);
            end
        end
        chk("full_done_seen", int'(found),     1);
        chk("full_ld_count",  got.size(),      19);
        for (int i = 0; i < 19 && i < got.size(); i++)
            chk("full_byte", int'(got[i]), int'(MSG[i]));
        @(negedge clk);
        chk("full_done_once", int'(done), 0);

        // start held high: back-to-back runs
        start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        chk("b2b_first_done", int'(found), 1);
        gap = 0; ldc = 0; found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            gap++;
            if (ldtxdata) ldc++;
            if (done) found = 1'b1;
        end
        start = 1'b0;
        chk("b2b_second_done", int'(found), 1);
        chk("b2b_gap",         gap,         59);
        chk("b2b_ld_count",    ldc,         19);

        // Abort with reset while in waitsend9
        @(negedge clk);
        txempty = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (int'(dut.state) == 30) found = 1'b1;
            else @(negedge clk);
        end
        chk("reach_waitsend9", int'(found), 1);
        txempty = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_state",  int'(dut.state), 0);
        chk("abort_ld",     int'(ldtxdata),  0);
        chk("abort_done",   int'(done),      0);
        chk("abort_txdata", int'(txdata),    0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_done", int'(done), 0);
        end

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n   = 1'b1;
            start   = ($urandom_range(0, 7) == 0);
            txempty = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 399) == 0) #2 rst_n = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
